// File: rtl/mux_input_conditioner.sv
// Input conditioning for a downstream 2:1 mux: synchronizes and debounces the two
// data switches and the select button, and derives a level- or toggle-mode select.
module mux_input_conditioner #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_raw,
  input  logic b_raw,
  input  logic sel_btn,
  input  logic toggle_mode,
  output logic a,
  output logic b,
  output logic sel,
  output logic sel_pulse
);

  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);
  localparam int unsigned A_CH = 0;
  localparam int unsigned B_CH = 1;
  localparam int unsigned S_CH = 2;
  localparam int unsigned M_CH = 3;

  // Bit order in both synchronizer stages: {toggle_mode, sel_btn, b_raw, a_raw}
  logic [3:0]    meta;
  logic [3:0]    synced;
  logic [2:0]    stable;
  logic [2:0]    stable_nxt;
  logic [CW-1:0] cnt     [3];
  logic [CW-1:0] cnt_nxt [3];
  logic          sel_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= '0;
      synced <= '0;
    end else begin
      meta   <= {toggle_mode, sel_btn, b_raw, a_raw};
      synced <= meta;
    end
  end

  // Counter tracks consecutive deviating cycles; it commits on the DEB_CYCLES-th one.
  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      stable_nxt[i] = stable[i];
      cnt_nxt[i]    = '0;
      if (synced[i] != stable[i]) begin
        if (cnt[i] == CNT_MAX) begin
          stable_nxt[i] = synced[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CW'(1);
        end
      end
    end
    sel_rise = stable_nxt[S_CH] & ~stable[S_CH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable    <= '0;
      sel_pulse <= 1'b0;
      sel       <= 1'b0;
      for (int unsigned i = 0; i < 3; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      stable    <= stable_nxt;
      sel_pulse <= sel_rise;
      for (int unsigned i = 0; i < 3; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
      // Level mode uses the next stable value so sel moves on the same edge as the button.
      if (!synced[M_CH]) begin
        sel <= stable_nxt[S_CH];
      end else if (sel_rise) begin
        sel <= ~sel;
      end
    end
  end

  assign a = stable[A_CH];
  assign b = stable[B_CH];

endmodule

// File: tb/tb_mux_input_conditioner.sv
// Scoreboard bench for mux_input_conditioner (DEB_CYCLES = 4): directed stimulus pushes
// hand-timed expected {a,b,sel,sel_pulse} snapshots, a negedge monitor pops and compares.
module tb_mux_input_conditioner;

  logic clk;
  logic rst_n;
  logic a_raw;
  logic b_raw;
  logic sel_btn;
  logic toggle_mode;
  logic a;
  logic b;
  logic sel;
  logic sel_pulse;
  logic [3:0] outs;

  typedef struct {
    int         cyc;
    logic [3:0] v;
    string      name;
  } exp_t;

  exp_t q[$];
  int   edges       = 0;
  int   checks      = 0;
  int   passes      = 0;
  int   pulses_seen = 0;
  int   exp_pulses  = 0;

  mux_input_conditioner #(.DEB_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a_raw       (a_raw),
    .b_raw       (b_raw),
    .sel_btn     (sel_btn),
    .toggle_mode (toggle_mode),
    .a           (a),
    .b           (b),
    .sel         (sel),
    .sel_pulse   (sel_pulse)
  );

  assign outs = {a, b, sel, sel_pulse};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edges <= edges + 1;

  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: {a,b,sel,pulse} got %b expected %b (edge %0d)", nm, act, req, edges - 1);
  endtask

  task automatic push(input int c, input logic [3:0] v, input string nm);
    exp_t e;
    e.cyc  = c;
    e.v    = v;
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic go(input int e);
    while (edges < e) @(negedge clk);
  endtask

  // Monitor: every entry due at the most recent edge is compared and retired.
  always @(negedge clk) begin
    if (sel_pulse === 1'b1) pulses_seen++;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc < edges - 1) begin
        checks++;
        $display("FAIL %s: expectation for edge %0d never compared (now %0d)", q[i].name, q[i].cyc, edges - 1);
        q.delete(i);
      end else if (q[i].cyc == edges - 1) begin
        check(q[i].name, outs, q[i].v);
        q.delete(i);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: stimulus did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n       = 1'b1;
    a_raw       = 1'b0;
    b_raw       = 1'b0;
    sel_btn     = 1'b0;
    toggle_mode = 1'b0;
    #1 rst_n = 1'b0;
    #1 check("reset_async_initial", outs, 4'b0000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = edges;
    push(n,     4'b0000, "reset_state_e0");
    push(n + 2, 4'b0000, "reset_state_e2");
    go(n + 4);

    // a_raw rise/fall with latency 5
    n = edges; a_raw = 1'b1;
    push(n + 4, 4'b0000, "a_before_latency");
    push(n + 5, 4'b1000, "a_rise_latency5");
    go(n + 10);
    n = edges; a_raw = 1'b0;
    push(n + 4, 4'b1000, "a_hold_before_fall");
    push(n + 5, 4'b0000, "a_fall_latency5");
    go(n + 8);

    // b_raw 3-cycle glitch rejected, 4-cycle pulse accepted
    n = edges; b_raw = 1'b1;
    push(n + 5, 4'b0000, "b_glitch3_e5");
    push(n + 8, 4'b0000, "b_glitch3_e8");
    go(n + 3); b_raw = 1'b0;
    go(n + 10);
    n = edges; b_raw = 1'b1;
    push(n + 4, 4'b0000, "b_before_rise");
    push(n + 5, 4'b0100, "b_rise");
    push(n + 8, 4'b0100, "b_before_fall");
    push(n + 9, 4'b0000, "b_fall");
    go(n + 4); b_raw = 1'b0;
    go(n + 12);

    // toggle mode: two clean presses
    toggle_mode = 1'b1;
    go(edges + 4);
    n = edges; sel_btn = 1'b1;
    exp_pulses += 2;
    push(n + 4,  4'b0000, "tog_before_press1");
    push(n + 5,  4'b0011, "tog_press1_pulse");
    push(n + 6,  4'b0010, "tog_press1_pulse_end");
    push(n + 13, 4'b0010, "tog_release1_hold");
    push(n + 22, 4'b0010, "tog_before_press2");
    push(n + 23, 4'b0001, "tog_press2_pulse");
    push(n + 24, 4'b0000, "tog_press2_pulse_end");
    push(n + 31, 4'b0000, "tog_release2_hold");
    go(n + 8);  sel_btn = 1'b0;
    go(n + 18); sel_btn = 1'b1;
    go(n + 26); sel_btn = 1'b0;
    go(n + 34);
    toggle_mode = 1'b0;
    go(edges + 4);

    // level mode: bouncing button then held
    n = edges;
    exp_pulses += 1;
    push(n + 8,  4'b0000, "bounce_no_change");
    push(n + 10, 4'b0000, "bounce_before_rise");
    push(n + 11, 4'b0011, "bounce_rise_pulse");
    push(n + 12, 4'b0010, "bounce_pulse_end");
    for (int i = 0; i < 6; i++) begin
      sel_btn = ((i % 2) == 0);
      go(n + i + 1);
    end
    sel_btn = 1'b1;
    go(n + 16);
    n = edges; sel_btn = 1'b0;
    push(n + 4, 4'b0010, "level_before_fall");
    push(n + 5, 4'b0000, "level_fall_no_pulse");
    go(n + 8);

    // a, b, sel_btn rise together: same-edge update
    n = edges; a_raw = 1'b1; b_raw = 1'b1; sel_btn = 1'b1;
    exp_pulses += 1;
    push(n + 4, 4'b0000, "simul_before");
    push(n + 5, 4'b1111, "simul_rise");
    push(n + 6, 4'b1110, "simul_pulse_end");
    go(n + 10);

    // reset while b counter = 2
    n = edges; b_raw = 1'b0;
    go(n + 4);
    #2 rst_n = 1'b0;
    #1 check("reset_async_midcount", outs, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    n = edges;
    exp_pulses += 1;
    push(n + 4, 4'b0000, "post_reset_before");
    push(n + 5, 4'b1011, "post_reset_rise");
    push(n + 6, 4'b1010, "post_reset_pulse_end");
    go(n + 8);

    // mode 0->1 holds sel; 1->0 re-tracks level
    n = edges; toggle_mode = 1'b1;
    push(n + 4, 4'b1010, "mode01_hold");
    go(n + 5);
    n = edges; sel_btn = 1'b0;
    push(n + 6, 4'b1010, "mode1_release_hold");
    go(n + 8);
    n = edges; toggle_mode = 1'b0;
    push(n + 1, 4'b1010, "mode10_sync_delay");
    push(n + 2, 4'b1000, "mode10_retrack");
    go(n + 5);

    checks++;
    if (pulses_seen == exp_pulses) passes++;
    else $display("FAIL pulse_count: got %0d expected %0d", pulses_seen, exp_pulses);
    checks++;
    if (q.size() == 0) passes++;
    else $display("FAIL queue_drain: got %0d pending expected 0", q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
